// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, defaults and helpers for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_ST = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam int DEPTH_DEF = 64;
  localparam int WAIT_DEF  = 2;

  // Number of word-index bits needed to address a memory of 'depth' words
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - synchronous single-port word RAM with registered read
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // One access per enabled edge: optional write, read returns the pre-write word
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder with alignment/range checking
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WAIT  = WAIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW     = idx_width(DEPTH);
  localparam logic [3:0] WAIT_L = 4'(WAIT);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        err_q;
  logic        load_q;

  logic        acc_en;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic [31:0] ram_rdata;

  // Misaligned or beyond the array: the access becomes an error, never a write
  assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (AW + 2)) != 32'd0);

  // Next-state and handshake decode; in IDLE the access uses the live request so
  // a zero-wait configuration can perform it on the accept edge
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    acc_en     = 1'b0;
    acc_we     = lat_we;
    acc_addr   = lat_addr;
    acc_wdata  = lat_wdata;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        acc_we    = req_we;
        acc_addr  = req_addr;
        acc_wdata = req_wdata;
        if (req_valid) begin
          if (WAIT == 0) begin
            acc_en   = 1'b1;
            state_nx = RESP;
          end else begin
            state_nx = WAIT_ST;
          end
        end
      end
      WAIT_ST: begin
        if (cnt == 4'd0) begin
          acc_en   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, wait counter, latched request and response flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      err_q     <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= WAIT_L;
      end else if (state == WAIT_ST && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (acc_en) begin
        err_q  <= acc_err;
        load_q <= !acc_we && !acc_err;
      end
    end
  end

  // Response data only exists in RESP and only for a good load
  assign resp_rdata = (state == RESP && load_q) ? ram_rdata : 32'd0;
  assign resp_err   = (state == RESP) && err_q;

  // Reset gating keeps a request presented during reset from touching memory
  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (acc_en && reset),
    .we    (acc_we && !acc_err),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed table-driven bench for dmem_responder
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        b_reset, b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

  dmem_responder #(.DEPTH(64), .WAIT(2)) dut_a (
    .clk(clk), .reset(a_reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dmem_responder #(.DEPTH(64), .WAIT(0)) dut_b (
    .clk(clk), .reset(b_reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one request to dut_a in IDLE, then scramble the bus to prove it is ignored
  task automatic issue_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    check("a_req_ready_idle", 32'(a_req_ready), 32'd1);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    a_req_we    = ~we;
    a_req_addr  = 32'h0000_0004;
    a_req_wdata = 32'h5555_AAAA;
  endtask

  // Count edges after the accept edge until resp_valid shows, bounded
  task automatic wait_resp_a(output int lat);
    lat = 0;
    while (!a_resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  vec_t va [15];
  vec_t vb [6];

  initial begin #500000; $display("FAIL watchdog: actual=timeout required=finish"); $fatal; end

  initial begin
    int lat;
    int k;
    int last_e;
    logic [31:0] held;

    va[0]  = '{1'b1, 32'h0000_0000, 32'hA5A5_0000, 32'h0, 1'b0};
    va[1]  = '{1'b1, 32'h0000_0008, 32'h0000_0808, 32'h0, 1'b0};
    va[2]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
    va[3]  = '{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0};
    va[4]  = '{1'b1, 32'h0000_0010, 32'h1111_2222, 32'h0, 1'b0};
    va[5]  = '{1'b0, 32'h0000_0013, 32'h0, 32'h0, 1'b1};
    va[6]  = '{1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0, 1'b1};
    va[7]  = '{1'b0, 32'h0000_0010, 32'h0, 32'h1111_2222, 1'b0};
    va[8]  = '{1'b1, 32'h0000_0100, 32'h0000_0BAD, 32'h0, 1'b1};
    va[9]  = '{1'b0, 32'h0000_0000, 32'h0, 32'hA5A5_0000, 1'b0};
    va[10] = '{1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 32'h0, 1'b0};
    va[11] = '{1'b0, 32'h0000_00FC, 32'h0, 32'h0BAD_F00D, 1'b0};
    va[12] = '{1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1};
    va[13] = '{1'b0, 32'h0000_0002, 32'h0, 32'h0, 1'b1};
    va[14] = '{1'b0, 32'h0000_0008, 32'h0, 32'h0000_0808, 1'b0};

    vb[0] = '{1'b1, 32'h0000_0020, 32'hCAFE_0001, 32'h0, 1'b0};
    vb[1] = '{1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_0001, 1'b0};
    vb[2] = '{1'b1, 32'h0000_0024, 32'h1357_2468, 32'h0, 1'b0};
    vb[3] = '{1'b0, 32'h0000_0024, 32'h0, 32'h1357_2468, 1'b0};
    vb[4] = '{1'b1, 32'h0000_0020, 32'h0F0F_0F0F, 32'h0, 1'b0};
    vb[5] = '{1'b0, 32'h0000_0020, 32'h0, 32'h0F0F_0F0F, 1'b0};

    a_reset = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    a_resp_ready = 1'b1;
    b_reset = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_resp_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_a_req_ready",  32'(a_req_ready),  32'd1);
    check("rst_a_resp_valid", 32'(a_resp_valid), 32'd0);
    check("rst_a_resp_rdata", a_resp_rdata,      32'd0);
    check("rst_a_resp_err",   32'(a_resp_err),   32'd0);
    check("rst_b_req_ready",  32'(b_req_ready),  32'd1);
    check("rst_b_resp_valid", 32'(b_resp_valid), 32'd0);
    a_reset = 1'b1;

    // Table: WAIT=2 transactions, response 3 edges after accept
    for (int i = 0; i < 15; i++) begin
      issue_a(va[i].we, va[i].addr, va[i].wdata);
      wait_resp_a(lat);
      check($sformatf("a_lat[%0d]", i),   32'(lat),            32'd3);
      check($sformatf("a_rdata[%0d]", i), a_resp_rdata,        va[i].exp_rdata);
      check($sformatf("a_err[%0d]", i),   32'(a_resp_err),     32'(va[i].exp_err));
      check($sformatf("a_rrdy[%0d]", i),  32'(a_req_ready),    32'd0);
      @(posedge clk);
      #1;
      check($sformatf("a_hs_idle[%0d]", i), 32'(a_resp_valid), 32'd0);
    end

    // Backpressure: response held steady for 5 cycles
    a_resp_ready = 1'b0;
    issue_a(1'b0, 32'h0000_0010, 32'h0);
    wait_resp_a(lat);
    check("bp_lat", 32'(lat), 32'd3);
    held = a_resp_rdata;
    check("bp_rdata0", held, 32'h1111_2222);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_valid",     32'(a_resp_valid), 32'd1);
      check("bp_rdata",     a_resp_rdata,      32'h1111_2222);
      check("bp_err",       32'(a_resp_err),   32'd0);
      check("bp_req_ready", 32'(a_req_ready),  32'd0);
    end
    @(negedge clk);
    a_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(a_resp_valid), 32'd0);
    check("bp_release_ready", 32'(a_req_ready),  32'd1);

    // Reset in the middle of a store's wait period
    issue_a(1'b1, 32'h0000_0008, 32'h1234_5678);
    @(posedge clk);
    #2;
    a_reset = 1'b0;
    #1;
    check("mid_rst_req_ready",  32'(a_req_ready),  32'd1);
    check("mid_rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check("mid_rst_resp_rdata", a_resp_rdata,      32'd0);
    check("mid_rst_resp_err",   32'(a_resp_err),   32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_resp", 32'(a_resp_valid), 32'd0);
    end
    @(negedge clk);
    a_reset = 1'b1;
    issue_a(1'b0, 32'h0000_0008, 32'h0);
    wait_resp_a(lat);
    check("mid_rst_lat",   32'(lat),          32'd3);
    check("mid_rst_old",   a_resp_rdata,      32'h0000_0808);
    check("mid_rst_err",   32'(a_resp_err),   32'd0);
    @(posedge clk);
    #1;

    // WAIT=0 back-to-back with resp_ready tied high: one transaction every 2 edges
    @(negedge clk);
    b_reset     = 1'b1;
    b_req_valid = 1'b1;
    b_req_we    = vb[0].we;
    b_req_addr  = vb[0].addr;
    b_req_wdata = vb[0].wdata;
    k = 0;
    last_e = 0;
    for (int e = 1; e <= 40 && k < 6; e++) begin
      @(posedge clk);
      #1;
      if (b_resp_valid) begin
        check($sformatf("b_gap[%0d]", k),   32'(e - last_e),  (k == 0) ? 32'd1 : 32'd2);
        check($sformatf("b_rdata[%0d]", k), b_resp_rdata,     vb[k].exp_rdata);
        check($sformatf("b_err[%0d]", k),   32'(b_resp_err),  32'(vb[k].exp_err));
        last_e = e;
        k++;
        if (k < 6) begin
          b_req_we    = vb[k].we;
          b_req_addr  = vb[k].addr;
          b_req_wdata = vb[k].wdata;
        end else begin
          b_req_valid = 1'b0;
        end
      end
    end
    check("b_count", 32'(k), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
